// File: rtl/pixel_stats_pkg.sv
// Shared constants and types for the per-frame pixel statistics block.
//   NUM_PIXELS/DATA_W/IDX_W/SUM_W/WSUM_W : default frame geometry and widths
//   state_e    : frame FSM encoding (IDLE, ACCUM, DONE)
//   ch_stats_t : one channel's peak index/value, intensity sum and weighted sum
package pixel_stats_pkg;

  localparam int NUM_PIXELS = 128;
  localparam int DATA_W     = 12;
  localparam int IDX_W      = 7;
  localparam int SUM_W      = 19;
  localparam int WSUM_W     = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  peak_idx;
    logic [DATA_W-1:0] peak_val;
    logic [SUM_W-1:0]  sum;
    logic [WSUM_W-1:0] wsum;
  } ch_stats_t;

endpackage

// File: rtl/pixel_frame_stats_if.sv
// Sample-in / result-out bus of pixel_frame_stats.
//   Sample side : frame_start, sample_valid, data1, data2, threshold
//   Result side : result_valid/result_ready handshake, per-channel peak,
//                 sums, plus overrun and frame_error event pulses
// Handshake: a result transfers on any cycle where result_valid && result_ready
// are both high at the rising edge; while result_valid=1 and result_ready=0 the
// result fields hold still (unless a newer frame overwrites them, flagged by
// overrun). The producer never waits on ready before raising valid.
// master = sample source / result consumer, slave = the statistics block.
interface pixel_frame_stats_if;
  import pixel_stats_pkg::*;

  logic              frame_start;
  logic              sample_valid;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] threshold;
  logic              result_ready;
  logic              result_valid;
  logic [IDX_W-1:0]  peak_idx1;
  logic [IDX_W-1:0]  peak_idx2;
  logic [DATA_W-1:0] peak_val1;
  logic [DATA_W-1:0] peak_val2;
  logic [SUM_W-1:0]  sum1;
  logic [SUM_W-1:0]  sum2;
  logic [WSUM_W-1:0] wsum1;
  logic [WSUM_W-1:0] wsum2;
  logic              overrun;
  logic              frame_error;

  modport master (
    output frame_start, sample_valid, data1, data2, threshold, result_ready,
    input  result_valid, peak_idx1, peak_idx2, peak_val1, peak_val2,
           sum1, sum2, wsum1, wsum2, overrun, frame_error
  );

  modport slave (
    input  frame_start, sample_valid, data1, data2, threshold, result_ready,
    output result_valid, peak_idx1, peak_idx2, peak_val1, peak_val2,
           sum1, sum2, wsum1, wsum2, overrun, frame_error
  );

endinterface

// File: rtl/pixel_channel_stats.sv
// One channel's running statistics: peak compare, threshold subtract and
// sum / index-weighted-sum accumulation.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : start a fresh frame (accumulators treated as zero this cycle)
//   en_i          : accept x_i as pixel idx_i this cycle
//   idx_i, x_i    : pixel index and sample
//   thr_i         : background level in force for this frame
//   stats_d_o     : next-state statistics, including this cycle's sample
module pixel_channel_stats
  import pixel_stats_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] thr_i,
  output ch_stats_t         stats_d_o
);

  ch_stats_t         stats_q, stats_d;
  logic [DATA_W-1:0] diff;

  always_comb begin
    diff    = x_i - thr_i;
    // A clear in the same cycle as a sample makes that sample pixel 0 of the
    // new frame, so accumulate on top of zero rather than the old totals.
    stats_d = clr_i ? '0 : stats_q;
    if (en_i) begin
      // Strict compare keeps the lowest index on ties.
      if (x_i > stats_d.peak_val) begin
        stats_d.peak_val = x_i;
        stats_d.peak_idx = idx_i;
      end
      if (x_i > thr_i) begin
        stats_d.sum  = stats_d.sum + SUM_W'(diff);
        stats_d.wsum = stats_d.wsum + WSUM_W'(idx_i) * WSUM_W'(diff);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stats_q <= '0;
    else       stats_q <= stats_d;
  end

  assign stats_d_o = stats_d;

endmodule

// File: rtl/pixel_frame_stats.sv
// Per-frame, per-channel pixel statistics (peak, above-threshold sum and
// index-weighted sum) for a linear-array readout, with a one-deep result
// register behind a valid/ready handshake.
//   fpga_clk, reset : clock, synchronous active-high reset
//   bus (slave)     : sample input, result output, overrun/frame_error pulses
//   dbg_state_o     : current frame FSM state
module pixel_frame_stats
  import pixel_stats_pkg::*;
(
  input  logic                      fpga_clk,
  input  logic                      reset,
  pixel_frame_stats_if.slave        bus,
  output state_e                    dbg_state_o
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic              ferr_q, ferr_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  ch_stats_t         res1_q, res1_d, res2_q, res2_d;
  ch_stats_t         nxt1, nxt2;

  logic              accept, complete;
  logic [IDX_W-1:0]  idx_cur;
  logic [DATA_W-1:0] thr_cur;

  // frame_start wins over everything: the coincident sample (if any) is pixel 0
  // and is judged against the threshold being latched in this very cycle.
  assign accept   = bus.sample_valid && (bus.frame_start || state_q == ACCUM);
  assign idx_cur  = bus.frame_start ? '0 : cnt_q;
  assign thr_cur  = bus.frame_start ? bus.threshold : thr_q;
  assign complete = accept && (idx_cur == IDX_W'(NUM_PIXELS - 1));

  pixel_channel_stats u_ch1 (
    .clk_i(fpga_clk), .rst_i(reset), .clr_i(bus.frame_start), .en_i(accept),
    .idx_i(idx_cur), .x_i(bus.data1), .thr_i(thr_cur), .stats_d_o(nxt1)
  );

  pixel_channel_stats u_ch2 (
    .clk_i(fpga_clk), .rst_i(reset), .clr_i(bus.frame_start), .en_i(accept),
    .idx_i(idx_cur), .x_i(bus.data2), .thr_i(thr_cur), .stats_d_o(nxt2)
  );

  // Frame FSM and pixel counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    ferr_d  = 1'b0;
    if (bus.frame_start) begin
      state_d = ACCUM;
      thr_d   = bus.threshold;
      cnt_d   = bus.sample_valid ? IDX_W'(1) : '0;
      // Restarting an untouched frame is harmless; abandoning one is not.
      ferr_d  = (state_q == ACCUM) && (cnt_q != '0);
    end else begin
      case (state_q)
        ACCUM:   if (accept) cnt_d = cnt_q + IDX_W'(1);
        IDLE:    ;
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
    if (complete) begin
      state_d = DONE;
      cnt_d   = '0;
    end
  end

  // Result register: the completing sample's next-state totals load directly,
  // so results appear on the edge that accepts the last pixel.
  always_comb begin
    valid_d = valid_q;
    ovr_d   = 1'b0;
    res1_d  = res1_q;
    res2_d  = res2_q;
    if (valid_q && bus.result_ready) valid_d = 1'b0;
    if (complete) begin
      valid_d = 1'b1;
      ovr_d   = valid_q && !bus.result_ready;
      res1_d  = nxt1;
      res2_d  = nxt2;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      thr_q   <= '0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.peak_idx1    = res1_q.peak_idx;
  assign bus.peak_val1    = res1_q.peak_val;
  assign bus.sum1         = res1_q.sum;
  assign bus.wsum1        = res1_q.wsum;
  assign bus.peak_idx2    = res2_q.peak_idx;
  assign bus.peak_val2    = res2_q.peak_val;
  assign bus.sum2         = res2_q.sum;
  assign bus.wsum2        = res2_q.wsum;
  assign bus.overrun      = ovr_q;
  assign bus.frame_error  = ferr_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pixel_frame_stats.sv
// Self-checking bench for pixel_frame_stats: table of full-frame vectors with
// hand-computed results, then directed sequences for latency, backpressure,
// short frames, coincident frame_start/sample and reset.
module tb_pixel_frame_stats;
  import pixel_stats_pkg::*;

  // ---------------- clock / reset ----------------
  logic   fpga_clk = 1'b0;
  logic   reset;
  state_e dbg_state;

  always #5 fpga_clk = ~fpga_clk;

  pixel_frame_stats_if bus ();

  pixel_frame_stats dut (
    .fpga_clk    (fpga_clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_RAMP = 0;
  localparam int K_SPOT = 1;
  localparam int K_TIE  = 2;

  typedef struct {
    int kind;
    int thr;
    int idx1, val1, sum1, wsum1;
    int idx2, val2, sum2, wsum2;
  } vec_t;

  vec_t vecs [4];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag,
                           input int i1, input int v1, input int s1, input int w1,
                           input int i2, input int v2, input int s2, input int w2);
    check({tag, ".valid"}, 32'(bus.result_valid), 1);
    check({tag, ".idx1"},  32'(bus.peak_idx1), i1);
    check({tag, ".val1"},  32'(bus.peak_val1), v1);
    check({tag, ".sum1"},  32'(bus.sum1), s1);
    check({tag, ".wsum1"}, 32'(bus.wsum1), w1);
    check({tag, ".idx2"},  32'(bus.peak_idx2), i2);
    check({tag, ".val2"},  32'(bus.peak_val2), v2);
    check({tag, ".sum2"},  32'(bus.sum2), s2);
    check({tag, ".wsum2"}, 32'(bus.wsum2), w2);
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [11:0] pix(input int kind, input int i, input int ch);
    case (kind)
      K_RAMP:  return (ch == 1) ? 12'(i) : 12'(4095 - i);
      K_SPOT:  return (ch == 1) ? ((i == 50) ? 12'd4000 : 12'd100) : 12'd0;
      default: return (ch == 1) ? ((i == 50 || i == 60) ? 12'd4000 : 12'd100) : 12'd7;
    endcase
  endfunction

  // Presents inputs for one cycle; returns #1 after the edge that sampled them.
  task automatic cyc(input logic fs, input logic sv, input logic [11:0] d1, input logic [11:0] d2);
    bus.frame_start  = fs;
    bus.sample_valid = sv;
    bus.data1        = d1;
    bus.data2        = d2;
    @(posedge fpga_clk);
    #1;
    bus.frame_start  = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  task automatic run_samples(input int kind, input int first, input int last);
    for (int i = first; i <= last; i++) cyc(1'b0, 1'b1, pix(kind, i, 1), pix(kind, i, 2));
  endtask

  // Threshold is scrambled after frame_start to show only the latched value counts.
  task automatic run_frame(input int kind, input int thr);
    bus.threshold = 12'(thr);
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    bus.threshold = 12'($urandom_range(0, 4095));
    run_samples(kind, 0, NUM_PIXELS - 1);
  endtask

  task automatic consume(input string tag);
    bus.result_ready = 1'b1;
    cyc(1'b0, 1'b0, 12'd0, 12'd0);
    bus.result_ready = 1'b0;
    check({tag, ".valid_clr"}, 32'(bus.result_valid), 0);
  endtask

  initial begin
    // ramp, thr 0: ch1 sum 0..127 = 8128, wsum sum i^2 = 690880;
    //   ch2 = 4095-i: sum 524160-8128, wsum 4095*8128-690880
    vecs[0] = '{K_RAMP, 0,   127, 127, 8128, 690880,   0, 4095, 516032, 32593280};
    // spot 4000@50 on 100 floor, thr 100: d=3900, wsum 50*3900; ch2 all zero
    vecs[1] = '{K_SPOT, 100,  50, 4000, 3900, 195000,  0, 0, 0, 0};
    // tie 4000@50 and @60: lowest index wins; wsum 3900*(50+60); ch2 flat 7 < thr
    vecs[2] = '{K_TIE,  100,  50, 4000, 7800, 429000,  0, 7, 0, 0};
    // ramp, thr 100: ch1 d=1..27 at i=101..127: sum 378, wsum 100*378+6930;
    //   ch2 d=3995-i all pixels: sum 511360-8128, wsum 3995*8128-690880
    vecs[3] = '{K_RAMP, 100, 127, 127, 378, 44730,     0, 4095, 503232, 31780480};

    reset            = 1'b1;
    bus.frame_start  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.data1        = '0;
    bus.data2        = '0;
    bus.threshold    = '0;
    bus.result_ready = 1'b0;
    repeat (2) @(posedge fpga_clk);
    #1;

    // Reset state
    check("rst.valid", 32'(bus.result_valid), 0);
    check("rst.val1",  32'(bus.peak_val1), 0);
    check("rst.sum2",  32'(bus.sum2), 0);
    check("rst.wsum1", 32'(bus.wsum1), 0);
    check("rst.ovr",   32'(bus.overrun), 0);
    check("rst.ferr",  32'(bus.frame_error), 0);
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Samples in IDLE must be ignored
    cyc(1'b0, 1'b1, 12'd4000, 12'd4000);
    check("idle.state", 32'(dbg_state), 32'(IDLE));

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_frame(vecs[v].kind, vecs[v].thr);
      check_res(tag, vecs[v].idx1, vecs[v].val1, vecs[v].sum1, vecs[v].wsum1,
                     vecs[v].idx2, vecs[v].val2, vecs[v].sum2, vecs[v].wsum2);
      check({tag, ".ovr"},   32'(bus.overrun), 0);
      check({tag, ".state"}, 32'(dbg_state), 32'(DONE));
      consume(tag);
    end

    // ---------------- latency: result 1 cycle after pixel 127 ----------------
    bus.threshold = 12'd0;
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    run_samples(K_RAMP, 0, NUM_PIXELS - 2);
    check("lat.early", 32'(bus.result_valid), 0);
    run_samples(K_RAMP, NUM_PIXELS - 1, NUM_PIXELS - 1);
    check("lat.valid", 32'(bus.result_valid), 1);
    check("lat.sum1",  32'(bus.sum1), 8128);

    // ---------------- backpressure: two frames unread ----------------
    repeat (3) cyc(1'b0, 1'b0, 12'd0, 12'd0);
    check("bp.hold_val1", 32'(bus.peak_val1), 127);
    check("bp.hold_valid", 32'(bus.result_valid), 1);
    bus.threshold = 12'd100;
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    run_samples(K_SPOT, 0, 64);
    check("bp.frozen_sum1", 32'(bus.sum1), 8128);
    check("bp.frozen_wsum1", 32'(bus.wsum1), 690880);
    check("bp.no_ovr_yet", 32'(bus.overrun), 0);
    run_samples(K_SPOT, 65, NUM_PIXELS - 1);
    check("bp.ovr_pulse", 32'(bus.overrun), 1);
    check_res("bp.f2", 50, 4000, 3900, 195000, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 12'd0, 12'd0);
    check("bp.ovr_once", 32'(bus.overrun), 0);
    check("bp.still_valid", 32'(bus.result_valid), 1);

    // Ready in the completion cycle: old transfers, new loads, no overrun
    bus.threshold = 12'd0;
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    run_samples(K_RAMP, 0, NUM_PIXELS - 2);
    bus.result_ready = 1'b1;
    run_samples(K_RAMP, NUM_PIXELS - 1, NUM_PIXELS - 1);
    check("rdy_cmpl.ovr",   32'(bus.overrun), 0);
    check("rdy_cmpl.valid", 32'(bus.result_valid), 1);
    check("rdy_cmpl.sum1",  32'(bus.sum1), 8128);
    consume("rdy_cmpl");

    // ---------------- short frame ----------------
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    run_samples(K_RAMP, 0, 39);
    bus.threshold = 12'd100;
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    check("short.ferr", 32'(bus.frame_error), 1);
    check("short.no_valid", 32'(bus.result_valid), 0);
    cyc(1'b0, 1'b0, 12'd0, 12'd0);
    check("short.ferr_once", 32'(bus.frame_error), 0);
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    check("restart0.no_ferr", 32'(bus.frame_error), 0);
    bus.threshold = 12'd3000;
    run_samples(K_SPOT, 0, NUM_PIXELS - 1);
    check_res("short.next", 50, 4000, 3900, 195000, 0, 0, 0, 0);
    consume("short");

    // ---------------- coincident frame_start + sample ----------------
    bus.threshold = 12'd0;
    cyc(1'b0, 1'b0, 12'd0, 12'd0);
    bus.threshold = 12'd150;
    cyc(1'b1, 1'b1, 12'd200, 12'd200);
    bus.threshold = 12'd0;
    cyc(1'b0, 1'b1, 12'd200, 12'd200);
    for (int i = 2; i < NUM_PIXELS; i++) cyc(1'b0, 1'b1, 12'd0, 12'd0);
    // pixels 0 and 1 each give d=50: sum 100, wsum 0*50+1*50; tie keeps idx 0
    check_res("coinc", 0, 200, 100, 50, 0, 200, 100, 50);
    repeat (3) cyc(1'b0, 1'b1, 12'd4000, 12'd4000);
    check("extra.val1",  32'(bus.peak_val1), 200);
    check("extra.sum2",  32'(bus.sum2), 100);
    check("extra.ovr",   32'(bus.overrun), 0);
    check("extra.state", 32'(dbg_state), 32'(DONE));
    consume("coinc");

    // ---------------- reset mid-frame ----------------
    bus.threshold = 12'd0;
    cyc(1'b1, 1'b0, 12'd0, 12'd0);
    run_samples(K_RAMP, 0, 63);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 12'd5, 12'd5);
    reset = 1'b0;
    check("rst_mid.valid", 32'(bus.result_valid), 0);
    check("rst_mid.ferr",  32'(bus.frame_error), 0);
    check("rst_mid.ovr",   32'(bus.overrun), 0);
    check("rst_mid.state", 32'(dbg_state), 32'(IDLE));
    repeat (2) cyc(1'b0, 1'b1, 12'd4000, 12'd4000);
    run_frame(K_RAMP, 0);
    check_res("rst_mid.next", 127, 127, 8128, 690880, 0, 4095, 516032, 32593280);

    // ---------------- reset while result pending ----------------
    reset = 1'b1;
    cyc(1'b0, 1'b0, 12'd0, 12'd0);
    reset = 1'b0;
    check("rst_hold.valid", 32'(bus.result_valid), 0);
    check("rst_hold.val1",  32'(bus.peak_val1), 0);
    check("rst_hold.idx1",  32'(bus.peak_idx1), 0);
    check("rst_hold.sum1",  32'(bus.sum1), 0);
    check("rst_hold.wsum2", 32'(bus.wsum2), 0);
    check("rst_hold.ovr",   32'(bus.overrun), 0);
    run_frame(K_TIE, 100);
    check_res("rst_hold.next", 50, 4000, 7800, 429000, 0, 7, 0, 0);
    check("rst_hold.next_ovr", 32'(bus.overrun), 0);
    consume("rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_stats.md
Name: pixel_frame_stats

Overview:
- Downstream of the sensor/ADC capture top level; consumes the per-pixel 12-bit words (Data1/Data2) produced for each linear-array readout.
- Per frame and per channel, computes the peak pixel (index, value), the above-threshold intensity sum and the index-weighted sum, so firmware can form a centroid as wsum/sum without a divider in fabric.
- Results are held in a one-deep output register with a valid/ready handshake.

Parameters:
- NUM_PIXELS, 128, pixels per frame (one sample per pixel per channel).
- DATA_W, 12, ADC sample width.
- IDX_W, 7, pixel index width; must satisfy 2^IDX_W >= NUM_PIXELS.
- SUM_W, 19, intensity-sum width (NUM_PIXELS*(2^DATA_W-1) fits).
- WSUM_W, 26, weighted-sum width (sum of i*(2^DATA_W-1) over all i fits).

Ports:
- fpga_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse aligned to the SI1 readout start; the next accepted sample is pixel 0.
- sample_valid  in  1  one-cycle strobe: data1/data2 hold a completed conversion.
- data1  in  DATA_W  channel 1 sample.
- data2  in  DATA_W  channel 2 sample.
- threshold  in  DATA_W  background level; sampled at frame_start and held for the whole frame.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result registers hold a complete frame.
- peak_idx1, peak_idx2  out  IDX_W  index of the maximum sample.
- peak_val1, peak_val2  out  DATA_W  maximum sample value.
- sum1, sum2  out  SUM_W  sum of (x - threshold) over pixels with x > threshold.
- wsum1, wsum2  out  WSUM_W  sum of i*(x - threshold) over the same pixels.
- overrun  out  1  one-cycle pulse: an unread result was overwritten.
- frame_error  out  1  one-cycle pulse: a frame was aborted before NUM_PIXELS samples.

Behaviour:
- Reset
  - All outputs are 0.
  - State is IDLE; pixel counter is 0.
  - Accumulators are cleared; the latched threshold is 0.
- States
  - IDLE: sample_valid is ignored. frame_start goes to ACCUM.
  - ACCUM: each sample_valid accepts one sample at index = counter, then the counter increments.
  - DONE: samples are ignored until the next frame_start.
- Entering ACCUM (frame_start)
  - Clear the accumulators, set the counter to 0 and latch threshold.
  - Set peak_val to 0 and peak_idx to 0.
  - If sample_valid is high in the same cycle, that sample is pixel 0 and is compared against the new threshold.
- Per-sample update
  - Peak: replace only if x > current peak, so the lowest index wins ties. An all-zero frame reports idx 0, val 0.
  - Sums: if x > threshold, add d = x - threshold to sum and add i*d to wsum. If x <= threshold, nothing is added.
  - Arithmetic is unsigned; widths are sized so no wrap is possible.
- Frame completion
  - When the sample at index NUM_PIXELS-1 is accepted, the final values (including that sample) are copied to the output registers on the next rising edge.
  - result_valid is asserted on that same edge, giving a latency of 1 cycle after the last sample.
  - State then goes to DONE.
- Handshake
  - The result transfers on a cycle with result_valid && result_ready; result_valid clears on the next edge.
  - Outputs are stable while result_valid=1 and result_ready=0.
- Overrun
  - A new completion while result_valid=1 and result_ready=0 overwrites the outputs and keeps result_valid=1.
  - overrun pulses for 1 cycle.
  - If ready is high in the completion cycle, the old result transfers, the new one loads, and there is no overrun.
- Short frame
  - frame_start in ACCUM with counter > 0 discards the partial data and pulses frame_error for 1 cycle.
  - The new frame begins normally.
  - frame_start in ACCUM with counter = 0 simply restarts, with no error.
- Reset mid-frame or mid-hold: everything clears next edge; a pending result is lost, and no overrun or frame_error is raised.
- The threshold input may change freely mid-frame; only the value latched at frame_start is used.

Decomposition:
- Package pixel_stats_pkg holds the default constants (NUM_PIXELS, DATA_W, IDX_W, SUM_W, WSUM_W) and the state encoding (IDLE, ACCUM, DONE).
- Sub-module pixel_channel_stats holds one channel's peak compare, threshold subtract and sum/wsum accumulators, with clear/enable/index inputs. It is instantiated twice; the parent owns the FSM, pixel counter, output registers and handshake.

Test Plan:
- Ramp frame: data1=i, data2=4095-i, threshold=0, ready=1 -> idx1=127/val1=127, idx2=0/val2=4095; sum1=8128, wsum1=690880; result_valid high exactly 1 cycle after the 128th sample.
- Single spot: data1=4000 at i=50, 100 elsewhere, threshold=100 -> idx1=50, val1=4000, sum1=3900, wsum1=195000. Tie case: 4000 at i=50 and i=60 -> idx1=50.
- Backpressure: ready=0 for two full frames -> outputs frozen after frame 1, then replaced by frame 2, overrun pulses once, result_valid stays 1; ready=1 -> result_valid falls next cycle.
- Short frame: frame_start after 40 samples -> frame_error pulses once, no result; the next full frame yields correct values counted from its pixel 0.
- Simultaneous frame_start+sample_valid with data=200, threshold changing from 0 to 150 in the same cycle -> pixel 0 contributes d=50; extra samples after index 127 are ignored.
- Reset asserted at sample 64 and while result_valid=1 -> all outputs 0 next edge; no overrun or frame_error pulse; a subsequent frame completes correctly.
